// File: rtl/filter_pkg.sv
// Shared definitions for the FIR MAC decimator: default widths, FSM encoding,
// legal decimation ratios and Q-format constants.
package filter_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_COEF_W    = 18;
  localparam int DEF_NUM_TAPS  = 32;
  localparam int DEF_ACC_WIDTH = 42;

  // Q1.15 sample times Q1.17 coefficient gives 32 fractional bits.
  localparam int ACC_FRAC = 32;

  localparam logic [4:0] DEC_1  = 5'd1;
  localparam logic [4:0] DEC_2  = 5'd2;
  localparam logic [4:0] DEC_4  = 5'd4;
  localparam logic [4:0] DEC_8  = 5'd8;
  localparam logic [4:0] DEC_16 = 5'd16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    FLUSH = 2'd2
  } mac_state_t;

  // Unsupported ratios fall back to no decimation.
  function automatic logic [4:0] legal_dec(input logic [4:0] dec);
    case (dec)
      DEC_1, DEC_2, DEC_4, DEC_8, DEC_16: legal_dec = dec;
      default:                            legal_dec = DEC_1;
    endcase
  endfunction

endpackage

// File: rtl/sample_delay_line.sv
// Circular sample buffer: one write per accepted sample, and a tap-offset read
// port that returns x[n-k] relative to the newest sample.
module sample_delay_line
  import filter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_NUM_TAPS,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     tap_offset,
  output logic [DATA_W-1:0] tap_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_addr_s;

  // Sample storage and write pointer; depth is a power of two so the pointer wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en) begin
      mem_r[wr_ptr_r] <= wr_data;
      wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
    end
  end

  // The newest sample sits one slot behind the write pointer.
  assign rd_addr_s = wr_ptr_r - AW'(1'b1) - tap_offset;
  assign tap_data  = mem_r[rd_addr_s];

endmodule

// File: rtl/fir_mac_decimator.sv
// Serial MAC FIR decimator: one tap per clock against a programmable coefficient
// bank, emitting the unrounded Q10.32 accumulator with a one-cycle strobe.
module fir_mac_decimator
  import filter_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int NUM_TAPS  = DEF_NUM_TAPS,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        valid_in,
  output logic                        ready,
  input  logic [4:0]                  dec_factor,
  input  logic                        coef_wr_en,
  input  logic [$clog2(NUM_TAPS)-1:0] coef_wr_addr,
  input  logic [COEF_W-1:0]           coef_wr_data,
  output logic [ACC_WIDTH-1:0]        acc_out,
  output logic                        acc_valid,
  output logic                        busy
);

  localparam int TAP_W  = $clog2(NUM_TAPS);
  localparam int PROD_W = DATA_W + COEF_W;

  if (ACC_WIDTH < DATA_W + COEF_W + TAP_W) begin : g_acc_width_check
    $error("ACC_WIDTH must be at least DATA_W + COEF_W + clog2(NUM_TAPS)");
  end
  if (NUM_TAPS < 2 || NUM_TAPS > 64 || (NUM_TAPS & (NUM_TAPS - 1)) != 0) begin : g_taps_check
    $error("NUM_TAPS must be a power of two between 2 and 64");
  end
  if ((DATA_W - 1) + (COEF_W - 1) != ACC_FRAC) begin : g_qformat_check
    $error("sample and coefficient fractional bits must sum to ACC_FRAC");
  end

  mac_state_t               state_r, state_nxt_s;
  logic                     ready_r, busy_r;
  logic [4:0]               phase_r, last_dec_r;
  logic [4:0]               dec_eff_s, phase_eff_s;
  logic                     accept_s, trigger_s, last_tap_s;
  logic [TAP_W-1:0]         tap_cnt_r;
  logic [COEF_W-1:0]        coef_r [NUM_TAPS];
  logic [COEF_W-1:0]        coef_s;
  logic [DATA_W-1:0]        tap_data_s;
  logic signed [PROD_W-1:0] prod_s, prod_r;
  logic                     prod_valid_r;
  logic signed [ACC_WIDTH-1:0] prod_ext_s, acc_r, acc_out_r;
  logic                     acc_valid_r;

  sample_delay_line #(
    .DATA_W (DATA_W),
    .DEPTH  (NUM_TAPS)
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (accept_s),
    .wr_data    (data_in),
    .tap_offset (tap_cnt_r),
    .tap_data   (tap_data_s)
  );

  // A ratio change restarts the phase so the current sample becomes phase 0.
  assign accept_s    = valid_in & ready_r;
  assign dec_eff_s   = legal_dec(dec_factor);
  assign phase_eff_s = (dec_eff_s != last_dec_r) ? 5'd0 : phase_r;
  assign trigger_s   = accept_s && (phase_eff_s == dec_eff_s - 5'd1);
  assign last_tap_s  = (tap_cnt_r == {TAP_W{1'b1}});

  // Next-state logic for the MAC sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (trigger_s) state_nxt_s = MAC;
        else           state_nxt_s = IDLE;
      end
      MAC: begin
        if (last_tap_s) state_nxt_s = FLUSH;
        else            state_nxt_s = MAC;
      end
      FLUSH:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register with registered handshake flags derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == IDLE);
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  // Phase counter and last sampled decimation ratio, both updated only on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r    <= 5'd0;
      last_dec_r <= DEC_1;
    end else if (accept_s) begin
      last_dec_r <= dec_eff_s;
      phase_r    <= trigger_s ? 5'd0 : phase_eff_s + 5'd1;
    end
  end

  // Coefficient bank; writes landing while a sequence runs are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        coef_r[i] <= '0;
      end
    end else if (coef_wr_en && !busy_r) begin
      coef_r[coef_wr_addr] <= coef_wr_data;
    end
  end

  assign coef_s     = coef_r[tap_cnt_r];
  assign prod_s     = $signed({{COEF_W{tap_data_s[DATA_W-1]}}, tap_data_s})
                    * $signed({{DATA_W{coef_s[COEF_W-1]}}, coef_s});
  assign prod_ext_s = {{(ACC_WIDTH-PROD_W){prod_r[PROD_W-1]}}, prod_r};

  // Tap sequencing, product pipeline register and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_cnt_r    <= '0;
      prod_r       <= '0;
      prod_valid_r <= 1'b0;
      acc_r        <= '0;
    end else begin
      prod_r       <= prod_s;
      prod_valid_r <= (state_r == MAC);
      if (state_r == IDLE && trigger_s) begin
        tap_cnt_r <= '0;
        acc_r     <= '0;
      end else begin
        if (state_r == MAC) tap_cnt_r <= tap_cnt_r + TAP_W'(1'b1);
        if (prod_valid_r)   acc_r     <= acc_r + prod_ext_s;
      end
    end
  end

  // Result register: FLUSH folds in the last product still in the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_out_r   <= '0;
      acc_valid_r <= 1'b0;
    end else begin
      acc_valid_r <= (state_r == FLUSH);
      if (state_r == FLUSH) acc_out_r <= acc_r + prod_ext_s;
    end
  end

  assign ready     = ready_r;
  assign busy      = busy_r;
  assign acc_out   = acc_out_r;
  assign acc_valid = acc_valid_r;

endmodule

// File: tb/tb_fir_mac_decimator.sv
// Randomized scoreboard bench for fir_mac_decimator: a queue-based behavioural
// model predicts each result and its cycle; a monitor checks DUT outputs.
module tb_fir_mac_decimator;

  localparam int DATA_W    = 16;
  localparam int COEF_W    = 18;
  localparam int NUM_TAPS  = 32;
  localparam int ACC_WIDTH = 42;
  localparam int TAP_W     = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DATA_W-1:0]    data_in;
  logic                 valid_in;
  logic                 ready;
  logic [4:0]           dec_factor;
  logic                 coef_wr_en;
  logic [TAP_W-1:0]     coef_wr_addr;
  logic [COEF_W-1:0]    coef_wr_data;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 acc_valid;
  logic                 busy;

  fir_mac_decimator #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .NUM_TAPS(NUM_TAPS), .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready(ready),
    .dec_factor(dec_factor), .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr),
    .coef_wr_data(coef_wr_data), .acc_out(acc_out), .acc_valid(acc_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint value;
    int     cyc;
  } exp_t;

  longint coef_m [NUM_TAPS];
  longint hist_m [$];
  longint obs_q  [$];
  exp_t   exp_q  [$];
  int     phase_m, last_dec_m, trig_cyc;
  int     checks = 0, passes = 0, pulses = 0;
  longint last_val = 0;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  task automatic note_fail(input string name);
    checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic int eff_dec(input int d);
    if (d == 1 || d == 2 || d == 4 || d == 8 || d == 16) return d;
    else return 1;
  endfunction

  // Busy covers the cycles following the trigger edge through trigger+NUM_TAPS.
  function automatic bit model_busy(input int c);
    return (c >= trig_cyc) && (c <= trig_cyc + NUM_TAPS);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_TAPS; i++) coef_m[i] = 0;
    hist_m.delete();
    exp_q.delete();
    phase_m    = 0;
    last_dec_m = 1;
    trig_cyc   = -1000;
  endtask

  // Drive one cycle from a negedge and advance the model across the next posedge.
  task automatic drive(input bit v, input logic [15:0] d, input logic [4:0] dec,
                       input bit we, input logic [4:0] wa, input logic [17:0] wd);
    int     ed, ph;
    longint s;
    exp_t   e;
    valid_in     = v;
    data_in      = d;
    dec_factor   = dec;
    coef_wr_en   = we;
    coef_wr_addr = wa;
    coef_wr_data = wd;
    if (!model_busy(cyc)) begin
      if (we) coef_m[wa] = longint'($signed(wd));
      if (v) begin
        hist_m.push_front(longint'($signed(d)));
        if (hist_m.size() > NUM_TAPS) void'(hist_m.pop_back());
        ed = eff_dec(int'(dec));
        ph = (ed != last_dec_m) ? 0 : phase_m;
        last_dec_m = ed;
        if (ph == ed - 1) begin
          phase_m = 0;
          s = 0;
          for (int k = 0; k < hist_m.size(); k++) s += coef_m[k] * hist_m[k];
          trig_cyc = cyc + 1;
          e.value  = s;
          e.cyc    = trig_cyc + NUM_TAPS + 1;
          exp_q.push_back(e);
        end else begin
          phase_m = ph + 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 5'd1, 1'b0, 5'd0, 18'h0);
  endtask

  task automatic write_coef(input logic [4:0] a, input logic [17:0] v);
    drive(1'b0, 16'h0, 5'd1, 1'b1, a, v);
  endtask

  // Hold valid with junk data while busy, then present the real sample.
  task automatic send(input logic [15:0] d, input logic [4:0] dec);
    int g = 0;
    while (model_busy(cyc) && g < 100) begin
      drive(1'b1, 16'($urandom), dec, 1'b0, 5'd0, 18'h0);
      g++;
    end
    drive(1'b1, d, dec, 1'b0, 5'd0, 18'h0);
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() > 0 || model_busy(cyc)) && g < 200) begin
      idle(1);
      g++;
    end
    if (g >= 200) begin
      note_fail("drain_timeout");
      exp_q.delete();
    end
    idle(2);
  endtask

  // Monitor: sampled 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        check("ready", longint'(ready), longint'(!model_busy(cyc)));
        check("busy", longint'(busy), longint'(model_busy(cyc)));
        if (acc_valid) begin
          if (exp_q.size() == 0) begin
            note_fail("unexpected_acc_valid");
          end else begin
            e = exp_q.pop_front();
            check("acc_latency", longint'(cyc), longint'(e.cyc));
            check("acc_out", longint'($signed(acc_out)), e.value);
            last_val = longint'($signed(acc_out));
            obs_q.push_back(last_val);
            pulses++;
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          note_fail("missing_acc_valid");
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [4:0] dec_tbl [8];
    logic [4:0] cur_dec;
    dec_tbl = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd3, 5'd0, 5'd7};
    rst = 1'b1;
    valid_in = 1'b0; data_in = '0; dec_factor = 5'd1;
    coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ready", longint'(ready), 1);
    check("rst_busy", longint'(busy), 0);
    check("rst_acc_valid", longint'(acc_valid), 0);
    check("rst_acc_out", longint'($signed(acc_out)), 0);
    rst = 1'b0;
    idle(2);

    // Impulse through h[k] = k+1.
    for (int k = 0; k < NUM_TAPS; k++) write_coef(5'(k), 18'(k + 1));
    obs_q.delete();
    send(16'd16384, 5'd1);
    for (int i = 0; i < NUM_TAPS; i++) send(16'd0, 5'd1);
    drain();
    check("impulse_first", obs_q.size() > 0 ? obs_q[0] : -1, 16384);
    check("impulse_last_tap", obs_q.size() > 31 ? obs_q[31] : -1, 32 * 16384);

    // DC response.
    for (int k = 0; k < NUM_TAPS; k++) write_coef(5'(k), 18'd4096);
    for (int i = 0; i < 40; i++) send(16'd32767, 5'd1);
    drain();
    check("dc_steady", last_val, 64'd4294836224);

    // Decimation by 4 over 64 accepted samples.
    pulses = 0;
    for (int i = 0; i < 64; i++) send(16'($urandom), 5'd4);
    drain();
    check("dec4_pulses", longint'(pulses), 16);

    // Coefficient write during busy is dropped; after busy it takes effect.
    send(16'd1234, 5'd1);
    idle(10);
    write_coef(5'd0, 18'd1000);
    send(16'd2000, 5'd1);
    drain();
    write_coef(5'd0, 18'd1000);
    send(16'd3000, 5'd1);
    drain();

    // Extremes: most negative samples and coefficients.
    for (int k = 0; k < NUM_TAPS; k++) write_coef(5'(k), 18'h20000);
    for (int i = 0; i < NUM_TAPS; i++) send(16'h8000, 5'd1);
    drain();
    check("extreme_no_wrap", last_val, 64'd137438953472);

    // Random traffic with ratio changes, illegal ratios and stray coefficient writes.
    cur_dec = 5'd1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0) cur_dec = dec_tbl[$urandom_range(0, 7)];
      drive(bit'($urandom_range(0, 1)), 16'($urandom), cur_dec,
            $urandom_range(0, 7) == 0, 5'($urandom), 18'($urandom));
    end
    drain();

    // Reset at cycle 10 of a MAC sequence.
    send(16'd5555, 5'd1);
    idle(10);
    rst = 1'b1;
    #1;
    check("midrst_ready", longint'(ready), 1);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_acc_out", longint'($signed(acc_out)), 0);
    check("midrst_acc_valid", longint'(acc_valid), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    for (int k = 0; k < NUM_TAPS; k++) write_coef(5'(k), 18'(k + 1));
    obs_q.delete();
    send(16'd16384, 5'd1);
    send(16'd0, 5'd1);
    drain();
    check("post_rst_impulse", obs_q.size() > 0 ? obs_q[0] : -1, 16384);
    check("post_rst_second", obs_q.size() > 1 ? obs_q[1] : -1, 2 * 16384);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
